// File: rtl/dmem_if.sv
// MEM-stage load/store bus between the pipeline and the data-memory responder.
// The master is the CPU; the slave serves the access and stalls the pipeline.
interface dmem_if;
   logic        MemRead_mem;
   logic        MemWrite_mem;
   logic [2:0]  Funct3_mem;
   logic [31:0] Addr_mem;
   logic [31:0] MemWriteData_mem;
   logic [31:0] MemDout_mem;
   logic        MemStall;
   logic        MemReady;
   logic        MisalignErr;

   modport master (
      output MemRead_mem, MemWrite_mem, Funct3_mem,
      output Addr_mem, MemWriteData_mem,
      input  MemDout_mem, MemStall, MemReady, MisalignErr
   );

   modport slave (
      input  MemRead_mem, MemWrite_mem, Funct3_mem,
      input  Addr_mem, MemWriteData_mem,
      output MemDout_mem, MemStall, MemReady, MisalignErr
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with fixed access latency, RV32I sizing,
// load extension and misalignment faulting for the MEM stage.
module dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input logic   clk,
   input logic   reset,
   dmem_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int AW = ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT =
      (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   logic [31:0]   mem_q [0:(1<<AW)-1];
   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    f3_q;
   logic          st_q;
   logic          ld_q;
   logic          ready_q;
   logic          err_q;
   logic [31:0]   dout_q;

   logic          req;
   logic          is_idle;
   logic          illegal;
   logic          misal;
   logic          fault;
   logic [AW+1:0] ld_addr;
   logic [2:0]    ld_f3;
   logic [31:0]   ld_word;
   logic [7:0]    ld_b;
   logic [15:0]   ld_h;
   logic [31:0]   ld_val;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic          unused_addr;

   assign unused_addr = ^bus.Addr_mem[31:AW+2];

   assign req     = bus.MemRead_mem | bus.MemWrite_mem;
   assign is_idle = (state_q == IDLE);

   assign bus.MemStall    = (is_idle & req) | (state_q == WAIT);
   assign bus.MemReady    = ready_q;
   assign bus.MisalignErr = err_q;
   assign bus.MemDout_mem = dout_q;

   always_comb begin
      illegal = 1'b1;
      case (bus.Funct3_mem)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = bus.MemWrite_mem;
         default:                illegal = 1'b1;
      endcase
      misal = (bus.Funct3_mem[1:0] == 2'b01 && bus.Addr_mem[0])
            | (bus.Funct3_mem[1:0] == 2'b10 && bus.Addr_mem[1:0] != 2'b00);
      fault = illegal | misal;
   end

   // with LATENCY=1 the load reads at acceptance, before anything is latched
   assign ld_addr = is_idle ? bus.Addr_mem[AW+1:0] : addr_q;
   assign ld_f3   = is_idle ? bus.Funct3_mem : f3_q;
   assign ld_word = mem_q[ld_addr[AW+1:2]];
   assign ld_b    = ld_word[{ld_addr[1:0], 3'b000} +: 8];
   assign ld_h    = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      ld_val = ld_word;
      case (ld_f3)
         3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
         3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
         3'b100:  ld_val = {24'd0, ld_b};
         3'b101:  ld_val = {16'd0, ld_h};
         default: ld_val = ld_word;
      endcase
   end

   always_comb begin
      be    = 4'hf;
      wlane = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_q[1:0];
            wlane = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
         end
         default: begin
            be    = 4'hf;
            wlane = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && state_q == RESP && st_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         st_q    <= 1'b0;
         ld_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= 32'd0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= bus.Addr_mem[AW+1:0];
                  wdata_q <= bus.MemWriteData_mem;
                  f3_q    <= bus.Funct3_mem;
                  st_q    <= bus.MemWrite_mem & ~fault;
                  ld_q    <= ~bus.MemWrite_mem & ~fault;
                  if (fault) begin
                     state_q <= RESP;
                     ready_q <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (LATENCY == 1) begin
                     state_q <= RESP;
                     ready_q <= 1'b1;
                     if (!bus.MemWrite_mem) dout_q <= ld_val;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
                  ready_q <= 1'b1;
                  if (ld_q) dout_q <= ld_val;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset-abort sequence,
// and random accesses checked against a byte-addressed memory model.
module tb_dmem_responder;
   localparam int AW  = 10;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   dmem_if bus ();

   dmem_responder #(
      .ADDR_WIDTH(AW),
      .LATENCY   (LAT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] dout;
   } vec_t;

   vec_t        tbl[$];
   logic [7:0]  ref_b [0:4095];
   logic [31:0] ref_dout;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   // Byte-level view of the RAM: size from funct3, faults from alignment.
   task automatic model_step(input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic err);
      int sz;
      int off;
      logic legal;
      logic [31:0] v;
      sz    = 1 << f3[1:0];
      off   = int'(a[11:0]);
      legal = wr ? (f3 <= 3'd2)
                 : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      err   = !legal || (off % sz != 0);
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < sz; b++) ref_b[off + b] = wd[8*b +: 8];
         end else begin
            v = 32'd0;
            for (int b = 0; b < sz; b++) v = v | (32'(ref_b[off + b]) << (8*b));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            ref_dout = v;
         end
      end
   endtask

   // Entered and left at posedge+1; request held until MemReady.
   task automatic do_access(input string nm, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic exp_err,
                            input logic [31:0] exp_dout);
      int n;
      int exp_lat;
      bus.MemRead_mem      = rd;
      bus.MemWrite_mem     = wr;
      bus.Funct3_mem       = f3;
      bus.Addr_mem         = a;
      bus.MemWriteData_mem = wd;
      exp_lat = exp_err ? 1 : LAT;
      @(negedge clk);
      chk({nm, "_stall_t"}, 32'(bus.MemStall), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.MemReady && n < 20);
      chk({nm, "_lat"}, n, exp_lat);
      chk({nm, "_err"}, 32'(bus.MisalignErr), 32'(exp_err));
      chk({nm, "_stall_r"}, 32'(bus.MemStall), 32'd0);
      chk({nm, "_dout"}, bus.MemDout_mem, exp_dout);
      @(posedge clk);
      #1;
      bus.MemRead_mem  = 1'b0;
      bus.MemWrite_mem = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic e;
      logic [31:0] r;
      logic [31:0] a;
      logic [2:0]  f3;
      int k;

      bus.MemRead_mem      = 1'b0;
      bus.MemWrite_mem     = 1'b0;
      bus.Funct3_mem       = 3'd0;
      bus.Addr_mem         = 32'd0;
      bus.MemWriteData_mem = 32'd0;
      ref_dout = 32'd0;
      for (int i = 0; i < 4096; i++) ref_b[i] = 8'd0;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.MemReady), 32'd0);
      chk("rst_stall", 32'(bus.MemStall), 32'd0);
      chk("rst_err", 32'(bus.MisalignErr), 32'd0);
      chk("rst_dout", bus.MemDout_mem, 32'd0);
      @(posedge clk);
      #1;

      for (int w = 0; w < (1 << AW); w++) begin
         model_step(1'b1, 3'd2, 32'(w * 4), 32'd0, e);
         do_access("init", 1'b0, 1'b1, 3'd2, 32'(w * 4), 32'd0, e, ref_dout);
      end

      tbl.push_back('{0, 1, 3'd2, 32'h40,   32'hDEADBEEF, 0, 32'h00000000});
      tbl.push_back('{1, 0, 3'd2, 32'h40,   32'h0,        0, 32'hDEADBEEF});
      tbl.push_back('{0, 1, 3'd2, 32'h40,   32'h0,        0, 32'hDEADBEEF});
      tbl.push_back('{0, 1, 3'd0, 32'h41,   32'h80,       0, 32'hDEADBEEF});
      tbl.push_back('{1, 0, 3'd0, 32'h41,   32'h0,        0, 32'hFFFFFF80});
      tbl.push_back('{1, 0, 3'd4, 32'h41,   32'h0,        0, 32'h00000080});
      tbl.push_back('{1, 0, 3'd2, 32'h40,   32'h0,        0, 32'h00008000});
      tbl.push_back('{0, 1, 3'd1, 32'h42,   32'h1234,     0, 32'h00008000});
      tbl.push_back('{1, 0, 3'd1, 32'h42,   32'h0,        0, 32'h00001234});
      tbl.push_back('{1, 0, 3'd2, 32'h40,   32'h0,        0, 32'h12348000});
      tbl.push_back('{1, 0, 3'd2, 32'h42,   32'h0,        1, 32'h12348000});
      tbl.push_back('{1, 0, 3'd2, 32'h40,   32'h0,        0, 32'h12348000});
      tbl.push_back('{0, 1, 3'd1, 32'h41,   32'hFFFF,     1, 32'h12348000});
      tbl.push_back('{0, 1, 3'd4, 32'h40,   32'hFF,       1, 32'h12348000});
      tbl.push_back('{1, 0, 3'd3, 32'h40,   32'h0,        1, 32'h12348000});
      tbl.push_back('{1, 0, 3'd6, 32'h40,   32'h0,        1, 32'h12348000});
      tbl.push_back('{1, 0, 3'd2, 32'h40,   32'h0,        0, 32'h12348000});
      tbl.push_back('{0, 1, 3'd2, 32'h1000, 32'hA5A5A5A5, 0, 32'h12348000});
      tbl.push_back('{1, 0, 3'd2, 32'h0,    32'h0,        0, 32'hA5A5A5A5});
      tbl.push_back('{1, 0, 3'd1, 32'h2,    32'h0,        0, 32'hFFFFA5A5});
      tbl.push_back('{1, 1, 3'd2, 32'h44,   32'h11223344, 0, 32'hFFFFA5A5});
      tbl.push_back('{1, 0, 3'd2, 32'h44,   32'h0,        0, 32'h11223344});
      tbl.push_back('{1, 0, 3'd5, 32'h46,   32'h0,        0, 32'h00001122});
      tbl.push_back('{1, 0, 3'd0, 32'h47,   32'h0,        0, 32'h00000011});
      tbl.push_back('{1, 0, 3'd1, 32'h45,   32'h0,        1, 32'h00000011});
      tbl.push_back('{0, 1, 3'd0, 32'h4B,   32'hFFFFFF7E, 0, 32'h00000011});
      tbl.push_back('{1, 0, 3'd2, 32'h48,   32'h0,        0, 32'h7E000000});

      foreach (tbl[i]) begin
         model_step(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, e);
         do_access($sformatf("v%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3,
                   tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].dout);
      end

      // store aborted by reset while in WAIT
      bus.MemWrite_mem     = 1'b1;
      bus.Funct3_mem       = 3'd2;
      bus.Addr_mem         = 32'h10;
      bus.MemWriteData_mem = 32'h55;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort_ready_w", 32'(bus.MemReady), 32'd0);
      chk("abort_stall_w", 32'(bus.MemStall), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.MemWrite_mem = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(bus.MemReady), 32'd0);
      chk("abort_stall", 32'(bus.MemStall), 32'd0);
      chk("abort_dout", bus.MemDout_mem, 32'd0);
      @(posedge clk);
      #1;
      ref_dout = 32'd0;
      model_step(1'b0, 3'd2, 32'h10, 32'd0, e);
      do_access("abort_lw", 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, e, ref_dout);

      for (int i = 0; i < 300; i++) begin
         r  = $urandom;
         a  = {r[31:12], 8'd0, r[3:0]};
         f3 = 3'($urandom_range(0, 7));
         k  = $urandom_range(0, 2);
         r  = $urandom;
         model_step(k != 0, f3, a, r, e);
         do_access($sformatf("rnd%0d", i), k != 1, k != 0, f3, a, r, e,
                   ref_dout);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
